// File: rtl/apb_uart_stream_master_pkg.sv
// Shared definitions for the UART stream master: register offsets, field positions,
// sequencer states and APB request/response bundles.
package apb_uart_stream_master_pkg;

    localparam logic [2:0] UART_OFS_STATUS = 3'd0;
    localparam logic [2:0] UART_OFS_DATA   = 3'd3;

    localparam int TX_BUSY_BIT     = 8;
    localparam int RX_EMPTY_BIT    = 31;
    localparam int RX_PARITY_BIT   = 30;
    localparam int RX_FRAMING_BIT  = 29;
    localparam int RX_OVERFLOW_BIT = 28;

    typedef enum logic [2:0] {
        IDLE,
        ST_SETUP,
        ST_ACCESS,
        WR_SETUP,
        WR_ACCESS,
        RD_SETUP,
        RD_ACCESS
    } uart_state_e;

    typedef struct packed {
        logic [31:0] paddr;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
    } apb_req_t;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        perr;
    } apb_rsp_t;

    function automatic logic [31:0] uart_addr(input logic [31:0] base, input logic [2:0] ofs);
        return base + {29'd0, ofs};
    endfunction

endpackage

// File: rtl/apb_uart_stream_master.sv
// APB master that turns a TX byte stream and an RX byte stream into status/data
// register accesses on the minimal UART target.
module apb_uart_stream_master
    import apb_uart_stream_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned POLL_GAP  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic [2:0]  rx_errors,
    input  logic        rx_ready,
    output logic        apb_error,
    output logic [31:0] apb_request__paddr,
    output logic        apb_request__psel,
    output logic        apb_request__penable,
    output logic        apb_request__pwrite,
    output logic [31:0] apb_request__pwdata,
    input  logic [31:0] apb_response__prdata,
    input  logic        apb_response__pready,
    input  logic        apb_response__perr
);

    localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);

    apb_req_t    req;
    apb_rsp_t    rsp;
    uart_state_e state_q, state_d;

    logic       last_grant_q, last_grant_d;
    logic       tx_hold_v_q, tx_hold_v_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [2:0] rx_errors_q, rx_errors_d;
    logic       apb_error_q, apb_error_d;
    logic [7:0] gap_q, gap_d;

    logic tx_pending, rx_due, grant_tx, grant_rx, in_access;
    logic unused_prdata_bits;

    assign rsp.prdata = apb_response__prdata;
    assign rsp.pready = apb_response__pready;
    assign rsp.perr   = apb_response__perr;
    assign unused_prdata_bits = ^rsp.prdata[27:9];

    assign tx_pending = tx_hold_v_q;
    assign rx_due     = !rx_valid_q && (gap_q == 8'd0);
    // last_grant_q flips on every grant; when both sides contend, it picks RX when set.
    assign grant_tx   = tx_pending && (!rx_due || !last_grant_q);
    assign grant_rx   = rx_due && (!tx_pending || last_grant_q);
    assign in_access  = (state_q == ST_ACCESS) || (state_q == WR_ACCESS) || (state_q == RD_ACCESS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_tx) begin
                    state_d      = ST_SETUP;
                    last_grant_d = !last_grant_q;
                end else if (grant_rx) begin
                    state_d      = RD_SETUP;
                    last_grant_d = !last_grant_q;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                // A busy transmitter or an error sends us back to arbitration; the byte stays held.
                if (rsp.pready) begin
                    state_d = (!rsp.perr && !rsp.prdata[TX_BUSY_BIT]) ? WR_SETUP : IDLE;
                end
            end
            WR_SETUP:  state_d = WR_ACCESS;
            WR_ACCESS: if (rsp.pready) state_d = IDLE;
            RD_SETUP:  state_d = RD_ACCESS;
            RD_ACCESS: if (rsp.pready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req = '0;
        case (state_q)
            ST_SETUP, ST_ACCESS: begin
                req.psel    = 1'b1;
                req.penable = (state_q == ST_ACCESS);
                req.paddr   = uart_addr(BASE_ADDR, UART_OFS_STATUS);
            end
            WR_SETUP, WR_ACCESS: begin
                req.psel    = 1'b1;
                req.penable = (state_q == WR_ACCESS);
                req.pwrite  = 1'b1;
                req.paddr   = uart_addr(BASE_ADDR, UART_OFS_DATA);
                req.pwdata  = {24'h0, tx_hold_q};
            end
            RD_SETUP, RD_ACCESS: begin
                req.psel    = 1'b1;
                req.penable = (state_q == RD_ACCESS);
                req.paddr   = uart_addr(BASE_ADDR, UART_OFS_DATA);
            end
            default: req = '0;
        endcase
    end

    always_comb begin
        tx_hold_d   = tx_hold_q;
        tx_hold_v_d = tx_hold_v_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        rx_errors_d = rx_errors_q;
        apb_error_d = apb_error_q;
        gap_d       = (gap_q == 8'd0) ? 8'd0 : gap_q - 8'd1;

        if (tx_valid && !tx_hold_v_q) begin
            tx_hold_d   = tx_data;
            tx_hold_v_d = 1'b1;
        end
        if (state_q == WR_ACCESS && rsp.pready && !rsp.perr) begin
            tx_hold_v_d = 1'b0;
        end

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (state_q == RD_ACCESS && rsp.pready) begin
            if (rsp.perr || rsp.prdata[RX_EMPTY_BIT]) begin
                gap_d = GAP_LOAD;
            end else begin
                rx_valid_d  = 1'b1;
                rx_data_d   = rsp.prdata[7:0];
                rx_errors_d = {rsp.prdata[RX_PARITY_BIT], rsp.prdata[RX_FRAMING_BIT],
                               rsp.prdata[RX_OVERFLOW_BIT]};
            end
        end

        if (in_access && rsp.pready && rsp.perr) begin
            apb_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b0;
            tx_hold_q    <= 8'h0;
            tx_hold_v_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'h0;
            rx_errors_q  <= 3'b0;
            apb_error_q  <= 1'b0;
            gap_q        <= 8'd0;
        end else begin
            last_grant_q <= last_grant_d;
            tx_hold_q    <= tx_hold_d;
            tx_hold_v_q  <= tx_hold_v_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_errors_q  <= rx_errors_d;
            apb_error_q  <= apb_error_d;
            gap_q        <= gap_d;
        end
    end

    assign tx_ready             = !tx_hold_v_q;
    assign rx_valid             = rx_valid_q;
    assign rx_data              = rx_data_q;
    assign rx_errors            = rx_errors_q;
    assign apb_error            = apb_error_q;
    assign apb_request__paddr   = req.paddr;
    assign apb_request__psel    = req.psel;
    assign apb_request__penable = req.penable;
    assign apb_request__pwrite  = req.pwrite;
    assign apb_request__pwdata  = req.pwdata;

endmodule

// File: tb/tb_apb_uart_stream_master.sv
// Directed bench for apb_uart_stream_master with a behavioural UART APB target model.
module tb_apb_uart_stream_master;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int          GAP  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, apb_error;
    logic [7:0]  tx_data, rx_data;
    logic [2:0]  rx_errors;
    logic [31:0] apb_request__paddr, apb_request__pwdata;
    logic        apb_request__psel, apb_request__penable, apb_request__pwrite;
    logic [31:0] apb_response__prdata = '0;
    logic        apb_response__pready = 1'b0;
    logic        apb_response__perr   = 1'b0;

    apb_uart_stream_master #(.BASE_ADDR(BASE), .POLL_GAP(GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_errors(rx_errors), .rx_ready(rx_ready),
        .apb_error(apb_error),
        .apb_request__paddr(apb_request__paddr), .apb_request__psel(apb_request__psel),
        .apb_request__penable(apb_request__penable), .apb_request__pwrite(apb_request__pwrite),
        .apb_request__pwdata(apb_request__pwdata),
        .apb_response__prdata(apb_response__prdata), .apb_response__pready(apb_response__pready),
        .apb_response__perr(apb_response__perr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } xfer_t;
    xfer_t log_q[$];

    // Target model knobs
    int          wait_cycles = 0;
    int          busy_left   = 0;
    int          perr_w_left = 0;
    logic [31:0] data_val    = 32'h5000_005A;

    int          wcnt = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_paddr, prev_pwdata;
    logic        prev_pwrite;

    always @(negedge clk) begin
        xfer_t x;
        if (!reset_n) begin
            apb_response__pready = 1'b0;
            apb_response__perr   = 1'b0;
            apb_response__prdata = '0;
            wcnt = 0;
            prev_wait = 1'b0;
        end else if (apb_request__psel && apb_request__penable) begin
            if (prev_wait) begin
                check("stable_paddr", apb_request__paddr, prev_paddr);
                check("stable_pwrite", apb_request__pwrite, prev_pwrite);
                check("stable_pwdata", apb_request__pwdata, prev_pwdata);
            end
            prev_paddr  = apb_request__paddr;
            prev_pwrite = apb_request__pwrite;
            prev_pwdata = apb_request__pwdata;
            if (wcnt < wait_cycles) begin
                apb_response__pready = 1'b0;
                apb_response__perr   = 1'b0;
                apb_response__prdata = '0;
                wcnt++;
                prev_wait = 1'b1;
            end else begin
                wcnt = 0;
                prev_wait = 1'b0;
                apb_response__pready = 1'b1;
                if (apb_request__pwrite) begin
                    apb_response__prdata = '0;
                    apb_response__perr   = (perr_w_left > 0);
                    if (perr_w_left > 0) perr_w_left--;
                end else if (apb_request__paddr == BASE) begin
                    apb_response__perr   = 1'b0;
                    apb_response__prdata = (busy_left > 0) ? 32'h0000_0100 : 32'h0;
                    if (busy_left > 0) busy_left--;
                end else begin
                    apb_response__perr   = 1'b0;
                    apb_response__prdata = data_val;
                end
                x.addr = apb_request__paddr;
                x.wr   = apb_request__pwrite;
                x.data = apb_request__pwrite ? apb_request__pwdata : apb_response__prdata;
                x.err  = apb_response__perr;
                x.cyc  = cyc;
                log_q.push_back(x);
                $display("xfer cyc=%0d %s addr=%h data=%h perr=%0d", cyc, x.wr ? "WR" : "RD",
                         x.addr, x.data, x.err);
            end
        end else begin
            apb_response__pready = 1'b0;
            apb_response__perr   = 1'b0;
            apb_response__prdata = '0;
            wcnt = 0;
            prev_wait = 1'b0;
        end
    end

    // Expected signals for the 0-wait single-byte TX, cycles 0..5 after the accept edge
    logic [3:0]  ctrl_exp [6] = '{4'b0000, 4'b0100, 4'b0110, 4'b0101, 4'b0111, 4'b1000};
    logic [31:0] addr_exp [6] = '{32'h0, BASE, BASE, BASE + 32'd3, BASE + 32'd3, 32'h0};
    logic [31:0] data_exp [6] = '{32'h0, 32'h0, 32'h0, 32'h41, 32'h41, 32'h0};

    int   n0, held, st, wr, rd, t_setup, last_l, nperr;
    logic seen, done;
    logic [31:0] last_wdata;
    bit   tok[$];

    initial begin
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_errors", rx_errors, 3'b000);
        check("rst_apb_error", apb_error, 1'b0);
        check("rst_apb_ctrl", {apb_request__psel, apb_request__penable, apb_request__pwrite}, 3'b000);
        check("rst_paddr", apb_request__paddr, 32'h0);
        check("rst_pwdata", apb_request__pwdata, 32'h0);
        reset_n = 1'b1;

        // RX byte with parity+overflow, consumer stalled
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rx_valid) seen = 1'b1;
        end
        check("rx_seen", seen, 1'b1);
        if (seen && log_q.size() > 0) check("rx_latency", cyc - log_q[$].cyc, 1);
        check("rx_data", rx_data, 8'h5A);
        check("rx_errors", rx_errors, 3'b101);
        n0 = log_q.size();
        held = 0;
        repeat (10) begin
            @(negedge clk);
            if (rx_valid && !apb_request__psel) held++;
        end
        check("rx_hold_no_poll", held, 10);
        check("rx_no_reads", log_q.size(), n0);

        // Single TX byte, zero waits, exact cycle profile
        check("tx1_ready_pre", tx_ready, 1'b1);
        tx_valid = 1'b1;
        tx_data  = 8'h41;
        @(posedge clk);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tx_valid = 1'b0;
                tx_data  = 8'hFF;
            end
            check($sformatf("tx1_ctrl_k%0d", k),
                  {tx_ready, apb_request__psel, apb_request__penable, apb_request__pwrite}, ctrl_exp[k]);
            check($sformatf("tx1_paddr_k%0d", k), apb_request__paddr, addr_exp[k]);
            if (k != 1 && k != 2) check($sformatf("tx1_pwdata_k%0d", k), apb_request__pwdata, data_exp[k]);
        end

        // TX with the transmitter busy for two status reads
        busy_left = 2;
        n0 = log_q.size();
        tx_valid = 1'b1;
        tx_data  = 8'h7E;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (tx_ready) done = 1'b1;
        end
        check("tx2_done", done, 1'b1);
        st = 0; wr = 0; rd = 0; last_wdata = '0;
        for (int i = n0; i < log_q.size(); i++) begin
            if (!log_q[i].wr && log_q[i].addr == BASE) st++;
            else if (log_q[i].wr) begin wr++; last_wdata = log_q[i].data; end
            else rd++;
        end
        check("tx2_status_reads", st, 3);
        check("tx2_writes", wr, 1);
        check("tx2_wdata", last_wdata, 32'h7E);
        check("tx2_no_rx_reads", rd, 0);
        if (log_q.size() > 0) check("tx2_last_is_write", log_q[$].wr, 1'b1);

        // Pop the byte, then empty polls must be spaced by the gap
        data_val = 32'h8000_0000;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx_pop", rx_valid, 1'b0);
        n0 = log_q.size();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (log_q.size() > n0) seen = 1'b1;
        end
        check("gap_poll1_seen", seen, 1'b1);
        last_l = seen ? log_q[n0].cyc : 0;
        t_setup = -1;
        held = 0;
        for (int i = 0; i < 50 && t_setup < 0; i++) begin
            @(negedge clk);
            if (rx_valid) held++;
            if (apb_request__psel && !apb_request__penable) t_setup = cyc;
        end
        check("gap_next_setup", t_setup - last_l, GAP + 2);
        check("gap_no_rx_valid", held, 0);

        // TX and RX both continuously pending with 3 wait states per access
        data_val    = 32'h0000_0033;
        rx_ready    = 1'b1;
        wait_cycles = 3;
        tx_data     = 8'h11;
        tx_valid    = 1'b1;
        n0 = log_q.size();
        tok.delete();
        for (int i = 0; i < 600 && tok.size() < 8; i++) begin
            @(negedge clk);
            tok.delete();
            for (int j = n0; j < log_q.size(); j++) begin
                if (!log_q[j].wr) tok.push_back(log_q[j].addr == BASE);
            end
        end
        check("arb_tokens", tok.size() >= 8, 1'b1);
        for (int i = 3; i < 8 && i < tok.size(); i++) begin
            check($sformatf("arb_alt_%0d", i), tok[i], !tok[i-1]);
        end
        tx_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (tx_ready) done = 1'b1;
        end
        check("arb_tx_drained", done, 1'b1);
        if (log_q.size() > 0) begin
            last_wdata = '0;
            for (int j = n0; j < log_q.size(); j++) if (log_q[j].wr) last_wdata = log_q[j].data;
            check("arb_wdata", last_wdata, 32'h11);
        end

        // perr on the write, then reset mid retry
        data_val    = 32'h8000_0000;
        wait_cycles = 4;
        perr_w_left = 1;
        n0 = log_q.size();
        tx_data  = 8'h5C;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (apb_error) seen = 1'b1;
        end
        check("perr_apb_error", seen, 1'b1);
        check("perr_byte_kept", tx_ready, 1'b0);
        nperr = 0;
        for (int j = n0; j < log_q.size(); j++) if (log_q[j].wr && log_q[j].err) nperr++;
        check("perr_write_logged", nperr, 1);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (apb_request__psel && apb_request__penable && apb_request__pwrite) seen = 1'b1;
        end
        check("retry_seen", seen, 1'b1);
        check("retry_pwdata", apb_request__pwdata, 32'h5C);
        check("retry_paddr", apb_request__paddr, BASE + 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("async_apb_ctrl", {apb_request__psel, apb_request__penable, apb_request__pwrite}, 3'b000);
        check("async_paddr", apb_request__paddr, 32'h0);
        check("async_pwdata", apb_request__pwdata, 32'h0);
        check("async_apb_error", apb_error, 1'b0);
        check("async_tx_ready", tx_ready, 1'b1);
        check("async_rx", {rx_valid, rx_data, rx_errors}, 12'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_cycles = 0;
        @(negedge clk);
        check("post_rst_apb_error", apb_error, 1'b0);
        check("post_rst_tx_ready", tx_ready, 1'b1);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
